grey_seq_ctrl: RTL and testbench
================================

Name: grey_seq_ctrl

Overview:
- Sequencer that steps a binary count between programmable bounds and drives it through binary-to-grey conversion (grey = bin ^ (bin >> 1)).
- Emits each grey word on a valid/ready stream, with one-shot, wrap and ping-pong modes.
- Sits in front of grey-coded consumers: pointer publishers, encoder emulation, low-toggle address buses.

Parameters:
- SIZE, 4, width of the count and of the grey word (min 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  pulse; accepted only in IDLE; captures lo, hi, mode.
- stop  in  1  abort request; honoured in RUN.
- mode  in  2  0 one-shot, 1 wrap, 2 ping-pong, 3 treated as one-shot.
- lo  in  SIZE  lower bound (binary), sampled on start.
- hi  in  SIZE  upper bound (binary), sampled on start.
- out_valid  out  1  grey_out/bin_out hold a word.
- out_ready  in  1  consumer accepts word when out_valid & out_ready.
- grey_out  out  SIZE  registered grey word.
- bin_out  out  SIZE  registered binary value matching grey_out.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after one-shot completes.
- wrap_pulse  out  1  one-cycle pulse on wrap or ping-pong turnaround.

Behaviour:
- Reset (async, any time, including mid-sequence): state IDLE; out_valid, busy, done, wrap_pulse, grey_out, bin_out, dir all 0.
- States: IDLE, RUN, DONE.
- Bounds: if lo > hi at start, hi_r = lo_r = lo, giving a single-word sequence.
- IDLE + start:
  - Next edge: RUN, bin = lo, grey = lo ^ (lo >> 1), out_valid = 1, busy = 1, dir = up.
  - Latency start to first valid: 1 cycle.
  - start outside IDLE is ignored.
- RUN, transfer (out_valid & out_ready): next word is loaded on the same edge, so zero-bubble streaming.
  - No transfer: outputs held stable, no change allowed while stalled.
- Step rule, up direction: bin < hi gives bin + 1. At bin == hi:
  - one-shot: DONE.
  - wrap: bin = lo, wrap_pulse.
  - ping-pong: dir = down, bin = hi - 1 (or hi if lo == hi), wrap_pulse.
- Step rule, down direction (ping-pong only): bin > lo gives bin - 1. At bin == lo: dir = up, bin = lo + 1 (or lo if lo == hi), wrap_pulse.
- grey_out and bin_out always update on the same edge. No combinational path from inputs to outputs.
- DONE: out_valid = 0, busy = 0, done = 1 for exactly one cycle, then IDLE.
- stop in RUN:
  - A transfer on the same cycle completes (that word counts as consumed).
  - Next edge: IDLE with out_valid = 0. No done pulse, no wrap_pulse.
  - stop in IDLE or DONE: no effect.
- start and stop together in IDLE: start wins. stop is only evaluated in RUN.
- Full range (lo = 0, hi = 2^SIZE - 1): wrap from hi to 0 is a single-bit grey change.
- Arithmetic is SIZE bits, unsigned. The ±1 step never overflows because bounds are checked first.

Optional Feature:
- GREY_SEQ_CHECK_EN: adds output seq_err (1 bit), reset 0.
  - Each transfer compares grey_out against the previous transferred word. popcount(xor) > 1 sets seq_err, except on transfers that follow a wrap-mode wrap with non-full range.
  - seq_err is sticky until the next accepted start or rst.
- Without the macro: no port and no compare logic.

Test Plan:
- SIZE=4, mode 0, lo=0, hi=4, out_ready=1 → grey 0000, 0001, 0011, 0010, 0110 on consecutive cycles; done pulses on the cycle after 0110; then IDLE.
- Mode 1, lo=2, hi=3, ready=1 for 6 transfers → 0011, 0010, 0011, 0010, ...; wrap_pulse on the cycle after each 0010 (bin 3) transfer.
- Mode 2, lo=5, hi=7 → bin 5, 6, 7, 6, 5, 6; wrap_pulse after bin 7 and after bin 5.
- Backpressure: ready low for 3 cycles at bin=9 → grey_out held at 1101, valid high; ready high advances to 1111 (bin 10).
- stop with a same-cycle transfer at bin=2, mode 1 → word 2 consumed; next cycle valid=0, busy=0, no done; rst asserted mid-run asynchronously clears all outputs before the next edge.
- With GREY_SEQ_CHECK_EN, mode 1 lo=0 hi=15 full run → seq_err stays 0; lo=9 > hi=3 → single word 1101 repeating, seq_err 0.

Source files
------------

// File: rtl/grey_seq_ctrl.sv
// Bounded binary sequencer with grey-coded valid/ready output (one-shot, wrap, ping-pong).
// Optional GREY_SEQ_CHECK_EN adds a sticky seq_err flag for multi-bit grey steps between transfers.
module grey_seq_ctrl #(
  parameter int unsigned SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic [1:0]      mode,
  input  logic [SIZE-1:0] lo,
  input  logic [SIZE-1:0] hi,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] grey_out,
  output logic [SIZE-1:0] bin_out,
  output logic            busy,
  output logic            done,
  output logic            wrap_pulse
`ifdef GREY_SEQ_CHECK_EN
  ,
  output logic            seq_err
`endif
);

  localparam logic [1:0] MODE_WRAP = 2'd1;
  localparam logic [1:0] MODE_PING = 2'd2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [1:0]      mode_q, mode_d;
  logic            dir_q, dir_d;  // 1 = counting down (ping-pong only)
  logic [SIZE-1:0] bin_d, grey_d;
  logic            valid_d, busy_d, done_d, wrap_d;
  logic            xfer;

  assign xfer = out_valid & out_ready;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      mode_q     <= '0;
      dir_q      <= 1'b0;
      bin_out    <= '0;
      grey_out   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      mode_q     <= mode_d;
      dir_q      <= dir_d;
      bin_out    <= bin_d;
      grey_out   <= grey_d;
      out_valid  <= valid_d;
      busy       <= busy_d;
      done       <= done_d;
      wrap_pulse <= wrap_d;
    end
  end

  // Next state, next word and pulse generation
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    bin_d   = bin_out;
    valid_d = out_valid;
    busy_d  = busy;
    done_d  = 1'b0;
    wrap_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          lo_d    = lo;
          hi_d    = (lo > hi) ? lo : hi;
          mode_d  = mode;
          dir_d   = 1'b0;
          bin_d   = lo;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (xfer) begin
          if (!dir_q) begin
            if (bin_out < hi_q) begin
              bin_d = bin_out + SIZE'(1);
            end else if (mode_q == MODE_WRAP) begin
              bin_d  = lo_q;
              wrap_d = 1'b1;
            end else if (mode_q == MODE_PING) begin
              dir_d  = 1'b1;
              bin_d  = (lo_q == hi_q) ? hi_q : hi_q - SIZE'(1);
              wrap_d = 1'b1;
            end else begin
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = DONE;
            end
          end else begin
            if (bin_out > lo_q) begin
              bin_d = bin_out - SIZE'(1);
            end else begin
              dir_d  = 1'b0;
              bin_d  = (lo_q == hi_q) ? lo_q : lo_q + SIZE'(1);
              wrap_d = 1'b1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    grey_d = bin_d ^ (bin_d >> 1);
  end

`ifdef GREY_SEQ_CHECK_EN
  logic [SIZE-1:0] prev_grey;
  logic            have_prev;
  logic            skip_next;
  logic            full_range;
  logic            multi_bit;

  assign full_range = (lo_q == '0) && (hi_q == '1);
  assign multi_bit  = $countones(grey_out ^ prev_grey) > 1;

  // A wrap-mode wrap over a partial range is a legal multi-bit jump; exempt the transfer after it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_grey <= '0;
      have_prev <= 1'b0;
      skip_next <= 1'b0;
      seq_err   <= 1'b0;
    end else if (state_q == IDLE && start) begin
      have_prev <= 1'b0;
      skip_next <= 1'b0;
      seq_err   <= 1'b0;
    end else if (xfer) begin
      if (have_prev && !skip_next && multi_bit) seq_err <= 1'b1;
      prev_grey <= grey_out;
      have_prev <= 1'b1;
      skip_next <= wrap_d && (mode_q == MODE_WRAP) && !full_range;
    end
  end
`endif

endmodule

// File: tb/tb_grey_seq_ctrl.sv
// Self-checking bench for grey_seq_ctrl: directed vectors plus randomized streams against a sequence model.
module tb_grey_seq_ctrl;
  localparam int unsigned SIZE = 4;

  logic            clk = 1'b0;
  logic            rst, start, stop, out_ready;
  logic [1:0]      mode;
  logic [SIZE-1:0] lo, hi;
  logic            out_valid, busy, done, wrap_pulse;
  logic [SIZE-1:0] grey_out, bin_out;
`ifdef GREY_SEQ_CHECK_EN
  logic            seq_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  grey_seq_ctrl #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .lo(lo), .hi(hi), .out_valid(out_valid), .out_ready(out_ready),
    .grey_out(grey_out), .bin_out(bin_out), .busy(busy), .done(done),
    .wrap_pulse(wrap_pulse)
`ifdef GREY_SEQ_CHECK_EN
    , .seq_err(seq_err)
`endif
  );

  always #5 clk = ~clk;

  // n-th word of a sequence over [lo_v, hi_v] (bounds already normalised)
  function automatic logic [SIZE-1:0] ref_word(input int lo_v, input int hi_v, input int md, input int n);
    int len, period, p;
    len = hi_v - lo_v + 1;
    if (md == 2) begin
      if (len == 1) return SIZE'(lo_v);
      period = 2 * (len - 1);
      p = n % period;
      return (p <= len - 1) ? SIZE'(lo_v + p) : SIZE'(lo_v + period - p);
    end else if (md == 1) begin
      return SIZE'(lo_v + (n % len));
    end
    return SIZE'(lo_v + n);
  endfunction

  // Whether transferring word n produces a wrap/turnaround pulse
  function automatic bit ref_turn(input int lo_v, input int hi_v, input int md, input int n);
    int len, period, p;
    len = hi_v - lo_v + 1;
    if (md == 1) return (n % len) == len - 1;
    if (md == 2) begin
      if (len == 1) return 1'b1;
      period = 2 * (len - 1);
      p = n % period;
      return (p == len - 1) || (p == 0 && n > 0);
    end
    return 1'b0;
  endfunction

  function automatic logic [SIZE-1:0] to_grey(input logic [SIZE-1:0] b);
    logic [SIZE-1:0] g;
    g[SIZE-1] = b[SIZE-1];
    for (int i = 0; i < SIZE - 1; i++) g[i] = b[i] ^ b[i+1];
    return g;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_checks++;
    if ({out_valid, busy, done, wrap_pulse, grey_out, bin_out} !== '0)
      $display("FAIL reset_outputs got %b want 0", {out_valid, busy, done, wrap_pulse, grey_out, bin_out});
    else n_pass++;
`ifdef GREY_SEQ_CHECK_EN
    n_checks++;
    if (seq_err !== 1'b0) $display("FAIL reset_seq_err got %b want 0", seq_err); else n_pass++;
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_known();
    logic [SIZE-1:0] exp_g [5];
    exp_g = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
    @(negedge clk);
    start = 1'b1; lo = 4'd0; hi = 4'd4; mode = 2'd0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || grey_out !== exp_g[i])
        $display("FAIL known_grey[%0d] got v=%b g=%b want v=1 g=%b", i, out_valid, grey_out, exp_g[i]);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if ({done, out_valid, busy} !== 3'b100)
      $display("FAIL known_done got d/v/b=%b want 100", {done, out_valid, busy});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({done, out_valid, busy} !== 3'b000)
      $display("FAIL known_idle got d/v/b=%b want 000", {done, out_valid, busy});
    else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_stream(input int lo_v, input int hi_v, input int md, input int max_x,
                             input int ready_pct, input string name);
    int elo, ehi, n, xfers, phase;
    bit one, ev, ew, ed, eb, fin;
    logic [SIZE-1:0] w;
    elo = lo_v; ehi = (lo_v > hi_v) ? lo_v : hi_v;
    one = (md == 0 || md == 3);
    n = 0; xfers = 0; phase = 0; ev = 1; ew = 0; ed = 0; eb = 1; fin = 0;
    @(negedge clk);
    start = 1'b1; stop = 1'($urandom_range(1)); out_ready = 1'b0;
    lo = SIZE'(lo_v); hi = SIZE'(hi_v); mode = 2'(md);
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      w = ref_word(elo, ehi, md, n);
      n_checks++;
      if (out_valid !== ev) $display("FAIL %s valid cyc=%0d got %b want %b", name, cyc, out_valid, ev);
      else n_pass++;
      if (ev) begin
        n_checks++;
        if (bin_out !== w) $display("FAIL %s bin cyc=%0d got %0d want %0d", name, cyc, bin_out, w);
        else n_pass++;
        n_checks++;
        if (grey_out !== to_grey(w))
          $display("FAIL %s grey cyc=%0d got %b want %b", name, cyc, grey_out, to_grey(w));
        else n_pass++;
      end
      n_checks++;
      if (wrap_pulse !== ew) $display("FAIL %s wrap cyc=%0d got %b want %b", name, cyc, wrap_pulse, ew);
      else n_pass++;
      n_checks++;
      if (done !== ed) $display("FAIL %s done cyc=%0d got %b want %b", name, cyc, done, ed);
      else n_pass++;
      n_checks++;
      if (busy !== eb) $display("FAIL %s busy cyc=%0d got %b want %b", name, cyc, busy, eb);
      else n_pass++;
`ifdef GREY_SEQ_CHECK_EN
      n_checks++;
      if (seq_err !== 1'b0) $display("FAIL %s seq_err cyc=%0d got %b want 0", name, cyc, seq_err);
      else n_pass++;
`endif
      if (phase == 2) begin
        fin = 1;
      end else begin
        out_ready = (int'($urandom_range(99)) < ready_pct);
        start = ($urandom_range(3) == 0);
        lo = SIZE'($urandom); hi = SIZE'($urandom); mode = 2'($urandom);
        stop = 1'b0;
        ew = 0; ed = 0;
        if (phase == 1) begin
          stop = 1'($urandom_range(1));
          ev = 0; eb = 0; phase = 2;
        end else if (out_ready) begin
          xfers++;
          if (one && w == SIZE'(ehi)) begin
            ev = 0; ed = 1; eb = 0; phase = 1;
          end else if (!one && xfers == max_x) begin
            stop = 1'b1; ev = 0; eb = 0; phase = 2;
          end else begin
            ew = ref_turn(elo, ehi, md, n);
            n++;
          end
        end
        @(negedge clk);
      end
    end
    start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    if (!fin) begin
      n_checks++;
      $display("FAIL %s timeout got running want idle", name);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    start = 1'b1; lo = 4'd9; hi = 4'd12; mode = 2'd0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || grey_out !== 4'b1101 || bin_out !== 4'd9)
        $display("FAIL bp_hold[%0d] got v=%b g=%b b=%0d want v=1 g=1101 b=9", i, out_valid, grey_out, bin_out);
      else n_pass++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || grey_out !== 4'b1111 || bin_out !== 4'd10)
      $display("FAIL bp_advance got v=%b g=%b b=%0d want v=1 g=1111 b=10", out_valid, grey_out, bin_out);
    else n_pass++;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_checks++;
    if ({out_valid, busy, done} !== 3'b000)
      $display("FAIL bp_stop got v/b/d=%b want 000", {out_valid, busy, done});
    else n_pass++;
  endtask

  task automatic test_stop_stalled();
    stop = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy, done} !== 3'b000)
      $display("FAIL stop_in_idle got v/b/d=%b want 000", {out_valid, busy, done});
    else n_pass++;
    stop = 1'b0;
    start = 1'b1; lo = 4'd0; hi = 4'd5; mode = 2'd1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_checks++;
    if ({out_valid, busy, done, wrap_pulse} !== 4'b0000)
      $display("FAIL stop_stalled got v/b/d/w=%b want 0000", {out_valid, busy, done, wrap_pulse});
    else n_pass++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start = 1'b1; lo = 4'd3; hi = 4'd8; mode = 2'd2; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, busy, done, wrap_pulse, grey_out, bin_out} !== '0)
      $display("FAIL async_reset got %b want 0", {out_valid, busy, done, wrap_pulse, grey_out, bin_out});
    else n_pass++;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    mode = 2'd0; lo = '0; hi = '0;
    test_reset();
    test_known();
    test_stream(2, 3, 1, 6, 100, "wrap_2_3");
    test_stream(5, 7, 2, 6, 100, "pingpong_5_7");
    test_backpressure();
    test_stream(0, 5, 1, 3, 100, "stop_xfer");
    test_stop_stalled();
    test_async_reset();
    test_stream(3, 8, 2, 14, 60, "pingpong_after_reset");
    test_stream(0, 15, 1, 20, 100, "wrap_full");
    test_stream(9, 3, 1, 5, 70, "inverted_bounds");
    test_stream(6, 6, 2, 4, 80, "pingpong_single");
    test_stream(4, 7, 3, 0, 50, "mode3_oneshot");
    for (int k = 0; k < 12; k++)
      test_stream(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(3)),
                  int'($urandom_range(25, 1)), int'($urandom_range(100, 30)), "random");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
